debounce_strobe: RTL and testbench



---
 rtl/debounce_strobe.sv | 128 ++++++++++++
 tb/tb_debounce_strobe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_strobe.sv
// Purpose : synchronize and debounce a raw input, emit a clean level plus change strobes.
// Latency : STABLE_CYCLES+2 clocks from the first new-level sample to d/en/rise/fall.
// Backpressure: none; free-running, one decision per clock, nothing is ever stalled.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   reset_n  - asynchronous active-low reset (released synchronously upstream)
//   din      - raw asynchronous input (button or switch)
//   d        - registered debounced level, drives the downstream latch data input
//   en       - registered one-cycle strobe in the cycle d changes (latch enable)
//   rise     - registered one-cycle strobe on an accepted 0->1 change of d
//   fall     - registered one-cycle strobe on an accepted 1->0 change of d
//   busy     - registered, high while a candidate change is being qualified
module debounce_strobe #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic d,
    output logic en,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    // Count value at which the current sample is the STABLE_CYCLES-th in a row.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Synchronizer, qualification FSM and all outputs share one register block so
    // every output is a flop and nothing combinational reaches a port from din.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE_LO;
            cnt   <= '0;
            d     <= 1'b0;
            en    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;

            // Strobes are single-cycle: cleared every clock unless set below.
            en   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;

            case (state)
                IDLE_LO: begin
                    if (s2) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end

                WAIT_HI: begin
                    if (!s2) begin
                        // Bounce: drop the candidate silently.
                        state <= IDLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        d     <= 1'b1;
                        en    <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                IDLE_HI: begin
                    if (!s2) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end

                WAIT_LO: begin
                    if (s2) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        d     <= 1'b0;
                        en    <= 1'b1;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    d     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_strobe.sv
// Purpose : self-checking bench for debounce_strobe with STABLE_CYCLES=4.
// Latency : expected outputs are taken one clock edge after each vector is driven.
// Backpressure: not applicable; the DUT has no flow control.
module tb_debounce_strobe;

    logic clk = 1'b0;
    logic reset_n;
    logic din;
    logic d;
    logic en;
    logic rise;
    logic fall;
    logic busy;

    always #5 clk = ~clk;

    debounce_strobe #(
        .STABLE_CYCLES(4),
        .CNT_W        (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (din),
        .d      (d),
        .en     (en),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
    );

    // One vector: din driven before a clock edge, and {d,en,rise,fall,busy}
    // expected just after that edge.
    typedef struct packed {
        logic       din;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [4:0] outs();
        return {d, en, rise, fall, busy};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: d/en/rise/fall/busy got %b want %b", name, act, exp);
        end
    endtask

    task automatic add(input logic di, input logic [4:0] e);
        vec_t v;
        v.din = di;
        v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, push the expectation, compare #1 after the
    // following rising edge.
    task automatic run_vecs(input string name);
        vec_t v;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            din = vecs[i].din;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s[%0d]: scoreboard empty", name, i);
            end else begin
                v = sb.pop_front();
                check($sformatf("%s[%0d]", name, i), outs(), v.exp);
            end
        end
        vecs.delete();
    endtask

    // Accepted 0->1 with din held high (d=0 beforehand).
    task automatic add_rise();
        add(1'b1, 5'b00000);
        add(1'b1, 5'b00000);
        add(1'b1, 5'b00001);
        add(1'b1, 5'b00001);
        add(1'b1, 5'b00001);
        add(1'b1, 5'b11100);
        add(1'b1, 5'b10000);
        add(1'b1, 5'b10000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tg [26];

        // Reset asserted with din high: outputs zero before any clock edge.
        reset_n = 1'b1;
        din     = 1'b1;
        #2 reset_n = 1'b0;
        #1 check("reset_async", outs(), 5'b00000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check($sformatf("reset_hold[%0d]", i), outs(), 5'b00000);
        end

        // Release with din still high: qualified from scratch.
        reset_n = 1'b1;
        add_rise();
        run_vecs("rise_after_reset");

        // d=1, din falls and holds.
        add(1'b0, 5'b10000);
        add(1'b0, 5'b10000);
        add(1'b0, 5'b10001);
        add(1'b0, 5'b10001);
        add(1'b0, 5'b10001);
        add(1'b0, 5'b01010);
        add(1'b0, 5'b00000);
        add(1'b0, 5'b00000);
        run_vecs("fall");

        // High for only 3 sampling edges: rejected, busy for 3 cycles.
        add(1'b1, 5'b00000);
        add(1'b1, 5'b00000);
        add(1'b1, 5'b00001);
        add(1'b0, 5'b00001);
        add(1'b0, 5'b00001);
        add(1'b0, 5'b00000);
        add(1'b0, 5'b00000);
        add(1'b0, 5'b00000);
        run_vecs("reject3");

        // Toggle every clock for 20 cycles, then hold low. No change is ever
        // accepted, so busy simply follows din two edges late.
        for (int k = 0; k < 26; k++) tg[k] = (k < 20) ? ((k % 2) == 0) : 1'b0;
        for (int k = 0; k < 26; k++) add(tg[k], {4'b0000, (k >= 2) ? tg[k-2] : 1'b0});
        run_vecs("toggle");

        // Reach WAIT_HI with cnt=2, then reset mid-count.
        add(1'b1, 5'b00000);
        add(1'b1, 5'b00000);
        add(1'b1, 5'b00001);
        add(1'b1, 5'b00001);
        run_vecs("pre_midreset");
        #2 reset_n = 1'b0;
        #1 check("midcount_reset_async", outs(), 5'b00000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 check($sformatf("midcount_reset_hold[%0d]", i), outs(), 5'b00000);
        end
        reset_n = 1'b1;
        add_rise();
        run_vecs("rise_after_midreset");

        // Reset while d=1 clears d without a clock edge.
        #2 reset_n = 1'b0;
        #1 check("reset_clears_d", outs(), 5'b00000);
        @(posedge clk);
        #1 check("reset_clears_d_hold", outs(), 5'b00000);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) add(1'b0, 5'b00000);
        run_vecs("idle_after_reset");

        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
